ld3320_result_dispatch: RTL and testbench
=========================================

LD3320_RESULT_DISPATCH -- requirements
Module: ld3320_result_dispatch

Interface
REQ-001 The block SHALL have parameter NUM_CMDS, default 8, meaning valid result codes are 0..NUM_CMDS-1 (range 1..8).
REQ-002 The block SHALL have parameter GUARD_CYC, default 1000, meaning the repeat-suppression window in sys_clk cycles (at least 1).
REQ-003 The block SHALL have parameter LED_HOLD, default 5000, meaning the LED display hold time in sys_clk cycles (at least 1).
REQ-004 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port sys_rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port result_ready, input, 1 bit: level from the recognizer, high while a result is presented.
REQ-007 The block SHALL have port result_code, input, 8 bits: recognized command index, valid while result_ready is high.
REQ-008 The block SHALL have port cmd_valid, output, 1 bit: the FIFO head is available.
REQ-009 The block SHALL have port cmd_code, output, 8 bits: the FIFO head code.
REQ-010 The block SHALL have port cmd_ready, input, 1 bit: consumer accept; a pop occurs on cmd_valid and cmd_ready both high.
REQ-011 The block SHALL have port led, output, 8 bits: one-hot of the last dispatched code during the hold window.
REQ-012 The block SHALL have port err_pulse, output, 1 bit: one-cycle pulse on an out-of-range code or on FIFO overflow.
REQ-013 The block SHALL have port dup_pulse, output, 1 bit: one-cycle pulse when a repeated code is suppressed.
REQ-014 The block SHALL have port accept_cnt, output, 8 bits: saturating count of codes pushed.
REQ-015 The block SHALL have port reject_cnt, output, 8 bits: saturating count of out-of-range, duplicate and overflow events.

Function
REQ-016 Edge detect: a result event SHALL occur in cycle N when result_ready=1 and its registered previous value is 0; result_code SHALL be sampled in cycle N.
REQ-017 Classification (combinational in cycle N) SHALL use this priority, highest first: out-of-range (code >= NUM_CMDS), then duplicate, then overflow, then accept.
REQ-018 Out-of-range: the block SHALL assert err_pulse in N+1, increment reject_cnt, and leave FIFO, guard and last_code unchanged.
REQ-019 Duplicate: when code == last_code, last_code is valid and the guard timer is nonzero, the block SHALL assert dup_pulse in N+1, increment reject_cnt, and not reload the guard.
REQ-020 FIFO: 4 entries deep with 2-bit read and write pointers wrapping modulo 4, and a 3-bit occupancy count.
REQ-021 Overflow: when occupancy is 4 and there is no pop in cycle N, the block SHALL drop the code, assert err_pulse in N+1, and increment reject_cnt.
REQ-022 Pop-while-full: when occupancy is 4 and a pop occurs in cycle N, the push SHALL be accepted and occupancy SHALL stay at 4.
REQ-023 Accept: the block SHALL write the code, set last_code to the code with the valid flag set, load the guard timer with GUARD_CYC, and increment accept_cnt.
REQ-024 Latency: after an accept into an empty FIFO, cmd_valid and cmd_code SHALL be visible in N+1.
REQ-025 Ordering: cmd_code SHALL present entries in FIFO order, and cmd_valid = (occupancy != 0).
REQ-026 Guard timer: the timer SHALL decrement by 1 per cycle while nonzero and saturate at 0.
REQ-027 Guard expiry: once the guard timer reaches 0, a repeat of the same code SHALL be accepted.
REQ-028 LED FSM states: the LED FSM SHALL have two states, IDLE (led=0) and SHOW (led = 1 << popped code).
REQ-029 LED entry: a pop SHALL move the LED FSM to SHOW in the next cycle and load the hold counter with LED_HOLD-1.
REQ-030 LED retrigger: a pop while in SHOW SHALL update led and reload the hold counter.
REQ-031 LED exit: the LED FSM SHALL return to IDLE when the hold counter reaches 0 with no pop in that cycle.
REQ-032 Counters: accept_cnt and reject_cnt SHALL hold at 255 and never wrap.
REQ-033 Result level: a result_ready held high for multiple cycles SHALL produce exactly one event.
REQ-034 Result width: codes 8..255 SHALL be out-of-range for every NUM_CMDS value.

Reset
REQ-035 While sys_rst=1 at a rising edge, the block SHALL clear cmd_valid, occupancy, pointers, led, err_pulse, dup_pulse, accept_cnt, reject_cnt, the guard timer and the hold counter to 0, set the LED FSM to IDLE, and clear the last_code valid flag.
REQ-036 Reset SHALL set the result_ready previous-value register to 1, so a level already high when reset releases produces no event.
REQ-037 Reset asserted mid-operation SHALL discard FIFO contents with no pop and no pulses.

Verification
REQ-038 Accept path: result_ready rises with code 3 and cmd_ready=0 -> in the next cycle cmd_valid=1, cmd_code=3, accept_cnt=1; then cmd_ready=1 for one cycle -> in the following cycle led=8'h08 and cmd_valid=0.
REQ-039 Guard window: code 2 accepted, then code 2 again 10 cycles later -> dup_pulse=1, accept_cnt=1, reject_cnt=1; code 2 again 1001 cycles after the accept -> accepted, accept_cnt=2.
REQ-040 Out-of-range: with NUM_CMDS=8, code 9 -> err_pulse=1, reject_cnt=1, cmd_valid unchanged; a following code 1 is accepted.
REQ-041 Overflow: cmd_ready=0 and codes 0,1,2,3,4 -> the fifth raises err_pulse; pop order is 0,1,2,3; then code 5 is pushed in the same cycle as a pop and occupancy stays 4.
REQ-042 LED hold and retrigger: LED_HOLD=4, one pop -> led nonzero for exactly 4 cycles; a second pop in the 3rd cycle -> new one-hot shown and held 4 more cycles.
REQ-043 Reset: sys_rst asserted with 3 entries queued -> in the next cycle all outputs are 0; result_ready held high across the reset release -> no event.

Source files
------------

// File: rtl/ld3320_result_dispatch_if.sv
// Handshake bundle between the LD3320 recognizer, the result dispatcher and the command consumer.
// The master side is the environment: it presents results and accepts commands.
interface ld3320_result_dispatch_if;
    logic       result_ready;
    logic [7:0] result_code;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       cmd_ready;

    modport master (
        output result_ready,
        output result_code,
        output cmd_ready,
        input  cmd_valid,
        input  cmd_code
    );

    modport slave (
        input  result_ready,
        input  result_code,
        input  cmd_ready,
        output cmd_valid,
        output cmd_code
    );
endinterface

// File: rtl/ld3320_result_dispatch.sv
// Filters LD3320 recognition results into a 4-deep command FIFO with range checking,
// repeat suppression, a one-hot LED display of dispatched commands and event counters.
module ld3320_result_dispatch #(
    parameter int NUM_CMDS  = 8,
    parameter int GUARD_CYC = 1000,
    parameter int LED_HOLD  = 5000
) (
    input  logic                        sys_clk,
    input  logic                        sys_rst,
    ld3320_result_dispatch_if.slave     bus,
    output logic [7:0]                  led,
    output logic                        err_pulse,
    output logic                        dup_pulse,
    output logic [7:0]                  accept_cnt,
    output logic [7:0]                  reject_cnt
);

    localparam int GW = $clog2(GUARD_CYC + 1);
    localparam int HW = $clog2(LED_HOLD + 1);
    localparam logic [7:0]    NUM_CMDS_C = 8'(NUM_CMDS);
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYC);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(LED_HOLD - 1);

    typedef enum logic [0:0] {
        LED_IDLE = 1'b0,
        LED_SHOW = 1'b1
    } led_state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    logic          rdy_prev_r;
    logic [7:0]    mem_r [4];
    logic [1:0]    wr_ptr_r;
    logic [1:0]    rd_ptr_r;
    logic [2:0]    count_r;
    logic [7:0]    last_code_r;
    logic          last_valid_r;
    logic [GW-1:0] guard_r;
    logic          cmd_valid_r;
    logic [7:0]    cmd_code_r;
    logic          err_r;
    logic          dup_r;
    logic [7:0]    acc_r;
    logic [7:0]    rej_r;
    led_state_t    state_r;
    logic [HW-1:0] hold_r;
    logic [7:0]    led_r;

    logic          event_s;
    logic          oor_s;
    logic          dup_s;
    logic          pop_s;
    logic          ovf_s;
    logic          push_s;
    logic [2:0]    count_nxt_s;
    logic [1:0]    rd_ptr_nxt_s;
    logic [7:0]    head_nxt_s;
    led_state_t    state_nxt_s;
    logic [HW-1:0] hold_nxt_s;
    logic [7:0]    led_nxt_s;

    // Classify a rising result_ready: range, then repeat, then FIFO room.
    always_comb begin
        event_s = bus.result_ready & ~rdy_prev_r;
        oor_s   = (bus.result_code >= NUM_CMDS_C);
        dup_s   = last_valid_r && (bus.result_code == last_code_r) && (guard_r != '0);
        pop_s   = cmd_valid_r & bus.cmd_ready;
        ovf_s   = (count_r == 3'd4) && !pop_s;
        push_s  = event_s && !oor_s && !dup_s && !ovf_s;
    end

    // Next occupancy, read pointer and head; a push into a slot that becomes the head bypasses memory.
    always_comb begin
        count_nxt_s  = count_r;
        rd_ptr_nxt_s = rd_ptr_r;
        head_nxt_s   = 8'd0;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + 3'd1;
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - 3'd1;
        end else begin
            count_nxt_s = count_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + 2'd1;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (count_nxt_s == 3'd0) begin
            head_nxt_s = 8'd0;
        end else if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = bus.result_code;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage, pointers and registered head presentation.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_r[i] <= 8'd0;
            end
            wr_ptr_r    <= 2'd0;
            rd_ptr_r    <= 2'd0;
            count_r     <= 3'd0;
            cmd_valid_r <= 1'b0;
            cmd_code_r  <= 8'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= bus.result_code;
                wr_ptr_r        <= wr_ptr_r + 2'd1;
            end
            rd_ptr_r    <= rd_ptr_nxt_s;
            count_r     <= count_nxt_s;
            cmd_valid_r <= (count_nxt_s != 3'd0);
            cmd_code_r  <= head_nxt_s;
        end
    end

    // Edge detector, repeat guard, pulses and saturating counters.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rdy_prev_r   <= 1'b1;
            last_code_r  <= 8'd0;
            last_valid_r <= 1'b0;
            guard_r      <= '0;
            err_r        <= 1'b0;
            dup_r        <= 1'b0;
            acc_r        <= 8'd0;
            rej_r        <= 8'd0;
        end else begin
            rdy_prev_r <= bus.result_ready;
            if (push_s) begin
                last_code_r  <= bus.result_code;
                last_valid_r <= 1'b1;
                guard_r      <= GUARD_LOAD;
            end else if (guard_r != '0) begin
                guard_r <= guard_r - GW'(1);
            end
            err_r <= event_s && (oor_s || (!dup_s && ovf_s));
            dup_r <= event_s && !oor_s && dup_s;
            if (push_s) begin
                acc_r <= sat_inc(acc_r);
            end
            if (event_s && !push_s) begin
                rej_r <= sat_inc(rej_r);
            end
        end
    end

    // LED FSM state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r <= LED_IDLE;
            hold_r  <= '0;
            led_r   <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            hold_r  <= hold_nxt_s;
            led_r   <= led_nxt_s;
        end
    end

    // LED FSM next state: every pop (re)starts the hold window with the popped code.
    always_comb begin
        state_nxt_s = state_r;
        hold_nxt_s  = hold_r;
        led_nxt_s   = led_r;
        case (state_r)
            LED_IDLE: begin
                if (pop_s) begin
                    state_nxt_s = LED_SHOW;
                    hold_nxt_s  = HOLD_LOAD;
                    led_nxt_s   = 8'd1 << cmd_code_r[2:0];
                end else begin
                    led_nxt_s = 8'd0;
                end
            end
            LED_SHOW: begin
                if (pop_s) begin
                    hold_nxt_s = HOLD_LOAD;
                    led_nxt_s  = 8'd1 << cmd_code_r[2:0];
                end else if (hold_r == '0) begin
                    state_nxt_s = LED_IDLE;
                    led_nxt_s   = 8'd0;
                end else begin
                    hold_nxt_s = hold_r - HW'(1);
                end
            end
            default: begin
                state_nxt_s = LED_IDLE;
                hold_nxt_s  = '0;
                led_nxt_s   = 8'd0;
            end
        endcase
    end

    assign bus.cmd_valid = cmd_valid_r;
    assign bus.cmd_code  = cmd_code_r;
    assign led           = led_r;
    assign err_pulse     = err_r;
    assign dup_pulse     = dup_r;
    assign accept_cnt    = acc_r;
    assign reject_cnt    = rej_r;

endmodule

// File: tb/tb_ld3320_result_dispatch.sv
// Directed bench for ld3320_result_dispatch; popped commands are checked by a scoreboard monitor.
module tb_ld3320_result_dispatch;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [7:0] led;
    logic       err_pulse;
    logic       dup_pulse;
    logic [7:0] accept_cnt;
    logic [7:0] reject_cnt;

    ld3320_result_dispatch_if bus ();

    ld3320_result_dispatch #(
        .NUM_CMDS  (8),
        .GUARD_CYC (1000),
        .LED_HOLD  (4)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .bus        (bus),
        .led        (led),
        .err_pulse  (err_pulse),
        .dup_pulse  (dup_pulse),
        .accept_cnt (accept_cnt),
        .reject_cnt (reject_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int         tests   = 0;
    int         fails   = 0;
    int         exp_acc = 0;
    int         exp_rej = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] code);
        bus.result_code  = code;
        bus.result_ready = 1'b1;
        step();
        bus.result_ready = 1'b0;
    endtask

    task automatic check_counts(input string name);
        check({name, "_acc"}, {24'd0, accept_cnt}, (exp_acc > 255) ? 32'd255 : 32'(exp_acc));
        check({name, "_rej"}, {24'd0, reject_cnt}, (exp_rej > 255) ? 32'd255 : 32'(exp_rej));
    endtask

    // Scoreboard monitor: a handshake seen mid-cycle pops at the next edge.
    always @(negedge sys_clk) begin
        if (!sys_rst && bus.cmd_valid && bus.cmd_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_order actual=%0h required=none", bus.cmd_code);
            end else begin
                mon_exp = exp_q.pop_front();
                if (bus.cmd_code !== mon_exp) begin
                    fails++;
                    $display("FAIL pop_order actual=%0h required=%0h", bus.cmd_code, mon_exp);
                end
            end
        end
    end

    initial begin
        sys_rst          = 1'b1;
        bus.result_ready = 1'b0;
        bus.result_code  = 8'd0;
        bus.cmd_ready    = 1'b0;
        repeat (3) step();
        sys_rst = 1'b0;
        step();
        check("rst_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("rst_led", {24'd0, led}, 32'd0);
        check("rst_err", {31'd0, err_pulse}, 32'd0);
        check("rst_dup", {31'd0, dup_pulse}, 32'd0);
        check_counts("rst");

        // accept path and LED hold of exactly four cycles
        exp_q.push_back(8'd3);
        exp_acc++;
        send(8'd3);
        check("acc_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check("acc_code", {24'd0, bus.cmd_code}, 32'd3);
        check_counts("acc");
        bus.cmd_ready = 1'b1;
        step();
        bus.cmd_ready = 1'b0;
        check("acc_led", {24'd0, led}, 32'h08);
        check("acc_pop_valid", {31'd0, bus.cmd_valid}, 32'd0);
        repeat (3) step();
        check("led_last_cycle", {24'd0, led}, 32'h08);
        step();
        check("led_expired", {24'd0, led}, 32'd0);

        // out-of-range codes, including the 8 boundary and a large code
        send(8'd9);
        exp_rej++;
        check("oor9_err", {31'd0, err_pulse}, 32'd1);
        check("oor9_dup", {31'd0, dup_pulse}, 32'd0);
        check("oor9_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check_counts("oor9");
        step();
        send(8'd8);
        exp_rej++;
        check("oor8_err", {31'd0, err_pulse}, 32'd1);
        step();
        send(8'd200);
        exp_rej++;
        check("oor200_err", {31'd0, err_pulse}, 32'd1);
        step();
        check("err_one_cycle", {31'd0, err_pulse}, 32'd0);
        check_counts("oor");
        exp_q.push_back(8'd1);
        exp_acc++;
        send(8'd1);
        check("after_oor_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check("after_oor_code", {24'd0, bus.cmd_code}, 32'd1);
        check_counts("after_oor");
        bus.cmd_ready = 1'b1;
        step();
        bus.cmd_ready = 1'b0;

        // a level held for several cycles is one event
        exp_q.push_back(8'd6);
        exp_acc++;
        bus.result_code  = 8'd6;
        bus.result_ready = 1'b1;
        repeat (4) step();
        bus.result_ready = 1'b0;
        step();
        check_counts("level");
        check("level_dup", {31'd0, dup_pulse}, 32'd0);
        bus.cmd_ready = 1'b1;
        step();
        bus.cmd_ready = 1'b0;
        check("level_single", {31'd0, bus.cmd_valid}, 32'd0);

        // repeat suppression window
        bus.cmd_ready = 1'b1;
        exp_q.push_back(8'd2);
        exp_acc++;
        send(8'd2);
        check_counts("guard_first");
        repeat (9) step();
        send(8'd2);
        exp_rej++;
        check("guard_dup", {31'd0, dup_pulse}, 32'd1);
        check("guard_dup_err", {31'd0, err_pulse}, 32'd0);
        check_counts("guard_dup");
        repeat (990) step();
        exp_q.push_back(8'd2);
        exp_acc++;
        send(8'd2);
        check("guard_expired_dup", {31'd0, dup_pulse}, 32'd0);
        check_counts("guard_expired");
        step();
        bus.cmd_ready = 1'b0;

        // overflow and pop-while-full
        repeat (1005) step();
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'(i));
            exp_acc++;
            send(8'(i));
            check("ovf_fill_err", {31'd0, err_pulse}, 32'd0);
            step();
        end
        send(8'd4);
        exp_rej++;
        check("ovf_err", {31'd0, err_pulse}, 32'd1);
        check_counts("ovf");
        step();
        exp_q.push_back(8'd5);
        exp_acc++;
        bus.cmd_ready = 1'b1;
        send(8'd5);
        bus.cmd_ready = 1'b0;
        check("popfull_err", {31'd0, err_pulse}, 32'd0);
        check("popfull_head", {24'd0, bus.cmd_code}, 32'd1);
        check_counts("popfull");
        step();
        send(8'd6);
        exp_rej++;
        check("still_full_err", {31'd0, err_pulse}, 32'd1);
        check_counts("still_full");
        bus.cmd_ready = 1'b1;
        repeat (4) step();
        bus.cmd_ready = 1'b0;
        check("drain_empty", {31'd0, bus.cmd_valid}, 32'd0);

        // LED retrigger in the third display cycle
        repeat (6) step();
        check("led_idle", {24'd0, led}, 32'd0);
        exp_q.push_back(8'd4);
        exp_q.push_back(8'd7);
        exp_acc += 2;
        send(8'd4);
        step();
        send(8'd7);
        step();
        bus.cmd_ready = 1'b1;
        step();
        bus.cmd_ready = 1'b0;
        check("led_show1", {24'd0, led}, 32'h10);
        step();
        check("led_show2", {24'd0, led}, 32'h10);
        step();
        check("led_show3", {24'd0, led}, 32'h10);
        bus.cmd_ready = 1'b1;
        step();
        bus.cmd_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("led_retrig", {24'd0, led}, 32'h80);
            step();
        end
        check("led_retrig_off", {24'd0, led}, 32'd0);

        // accept counter saturation with alternating codes
        bus.cmd_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            exp_q.push_back(8'(i % 2));
            exp_acc++;
            send(8'(i % 2));
            step();
        end
        bus.cmd_ready = 1'b0;
        check_counts("sat");

        // reset with three queued entries and result_ready high across release
        repeat (2) step();
        send(8'd3);
        step();
        send(8'd4);
        step();
        send(8'd5);
        step();
        check("pre_rst_valid", {31'd0, bus.cmd_valid}, 32'd1);
        bus.result_code  = 8'd2;
        bus.result_ready = 1'b1;
        sys_rst          = 1'b1;
        step();
        exp_acc = 0;
        exp_rej = 0;
        check("mid_rst_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check("mid_rst_code", {24'd0, bus.cmd_code}, 32'd0);
        check("mid_rst_led", {24'd0, led}, 32'd0);
        check("mid_rst_err", {31'd0, err_pulse}, 32'd0);
        check("mid_rst_dup", {31'd0, dup_pulse}, 32'd0);
        check_counts("mid_rst");
        step();
        sys_rst = 1'b0;
        repeat (2) step();
        check("rst_level_valid", {31'd0, bus.cmd_valid}, 32'd0);
        check_counts("rst_level");
        bus.result_ready = 1'b0;
        step();
        exp_q.push_back(8'd2);
        exp_acc++;
        send(8'd2);
        check("post_rst_valid", {31'd0, bus.cmd_valid}, 32'd1);
        check("post_rst_code", {24'd0, bus.cmd_code}, 32'd2);
        check_counts("post_rst");
        bus.cmd_ready = 1'b1;
        step();
        bus.cmd_ready = 1'b0;
        step();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
